// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle fetch/decode/execute/writeback controller for the
//            8-bit core. Fetches 16-bit instructions over a req/ack handshake,
//            presents the opcode to the decoder ROM, latches its ALU control
//            and load-immediate flag, and drives regfile/ALU/writeback control.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1     clock, rising edge
//   rst_n         in   1     asynchronous active-low reset
//   run           in   1     1 = free-run, 0 = stop after current instruction
//   step          in   1     in IDLE: execute exactly one instruction
//   imem_req      out  1     fetch request (high for the whole FETCH state)
//   imem_addr     out  PC_W  fetch address (= pc)
//   imem_ack      in   1     fetch complete, imem_data valid this cycle
//   imem_data     in   16    instruction {op, rd, ra, rb} / {op, rd, imm}
//   dec_opcode    out  4     opcode to decoder ROM (from IR)
//   dec_alu_flags in   8     decoder ROM ALU control
//   dec_ldi       in   1     decoder ROM load-immediate flag
//   alu_flags     out  8     registered ALU control
//   rf_ra/rf_rb   out  4     regfile read addresses
//   rf_we         out  1     regfile write enable (one-cycle pulse in WB)
//   rf_wa         out  4     regfile write address
//   wb_sel_imm    out  1     1 = write imm, 0 = write ALU result
//   imm           out  8     immediate = IR[7:0]
//   pc            out  PC_W  current program counter
//   busy          out  1     high in every state except IDLE
// ============================================================================
module cpu_sequencer #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   input  logic            step,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_data,
   output logic [3:0]      dec_opcode,
   input  logic [7:0]      dec_alu_flags,
   input  logic            dec_ldi,
   output logic [7:0]      alu_flags,
   output logic [3:0]      rf_ra,
   output logic [3:0]      rf_rb,
   output logic            rf_we,
   output logic [3:0]      rf_wa,
   output logic            wb_sel_imm,
   output logic [7:0]      imm,
   output logic [PC_W-1:0] pc,
   output logic            busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;
   logic [7:0]      r_alu_flags;
   logic            r_ldi_q;
   logic [3:0]      r_ra;
   logic [3:0]      r_rb;
   logic [3:0]      r_wa;
   logic [7:0]      r_imm;
   logic            r_wb_sel_imm;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic. run wins over step in IDLE; in WB only run decides
   // whether to continue, so a step arriving there is seen again in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (run || step) w_state_nxt = S_FETCH;
         S_FETCH:  if (imem_ack)    w_state_nxt = S_DECODE;
         S_DECODE: w_state_nxt = S_EXEC;
         S_EXEC:   w_state_nxt = S_WB;
         S_WB:     w_state_nxt = run ? S_FETCH : S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath registers, each loaded in the single state that owns it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= '0;
         r_ir         <= '0;
         r_alu_flags  <= '0;
         r_ldi_q      <= 1'b0;
         r_ra         <= '0;
         r_rb         <= '0;
         r_wa         <= '0;
         r_imm        <= '0;
         r_wb_sel_imm <= 1'b0;
      end else begin
         if ((r_state == S_FETCH) && imem_ack) begin
            r_ir <= imem_data;
         end
         if (r_state == S_DECODE) begin
            r_alu_flags <= dec_alu_flags;
            r_ldi_q     <= dec_ldi;
            r_ra        <= r_ir[7:4];
            r_rb        <= r_ir[3:0];
            r_wa        <= r_ir[11:8];
            r_imm       <= r_ir[7:0];
         end
         if (r_state == S_EXEC) begin
            r_wb_sel_imm <= r_ldi_q;
         end
         if (r_state == S_WB) begin
            // Natural wrap modulo 2**PC_W
            r_pc <= r_pc + 1'b1;
         end
      end
   end

   // Handshake/strobe outputs decode straight from the state register so that
   // an asynchronous reset drops them in the same cycle.
   assign imem_req   = (r_state == S_FETCH);
   assign rf_we      = (r_state == S_WB);
   assign busy       = (r_state != S_IDLE);

   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign dec_opcode = r_ir[15:12];
   assign alu_flags  = r_alu_flags;
   assign rf_ra      = r_ra;
   assign rf_rb      = r_rb;
   assign rf_wa      = r_wa;
   assign imm        = r_imm;
   assign wb_sel_imm = r_wb_sel_imm;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Self-checking bench for cpu_sequencer. An instruction-memory
//            responder issues fetches with random wait states and pushes the
//            expected writeback of each instruction into a scoreboard; a
//            monitor pops one entry per rf_we pulse and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

   localparam int PC_W = 8;

   logic            clk;
   logic            rst_n;
   logic            run;
   logic            step;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_data;
   logic [3:0]      dec_opcode;
   logic [7:0]      dec_alu_flags;
   logic            dec_ldi;
   logic [7:0]      alu_flags;
   logic [3:0]      rf_ra;
   logic [3:0]      rf_rb;
   logic            rf_we;
   logic [3:0]      rf_wa;
   logic            wb_sel_imm;
   logic [7:0]      imm;
   logic [PC_W-1:0] pc;
   logic            busy;

   cpu_sequencer #(.PC_W(PC_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_data(imem_data), .dec_opcode(dec_opcode),
      .dec_alu_flags(dec_alu_flags), .dec_ldi(dec_ldi),
      .alu_flags(alu_flags), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_we(rf_we),
      .rf_wa(rf_wa), .wb_sel_imm(wb_sel_imm), .imm(imm), .pc(pc),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decoder ROM stand-in: add=0, sub=ci|nb, ldi=0 with ldi flag, others
   // an arbitrary opcode-dependent pattern.
   function automatic logic [7:0] rom_flags(input logic [3:0] op);
      case (op)
         4'h0:    return 8'h00;
         4'h1:    return 8'hC0;
         4'hF:    return 8'h00;
         default: return {op, op ^ 4'h5};
      endcase
   endfunction

   assign dec_alu_flags = rom_flags(dec_opcode);
   assign dec_ldi       = (dec_opcode == 4'hF);

   typedef struct {
      logic [3:0]      op;
      logic [3:0]      wa;
      logic [3:0]      ra;
      logic [3:0]      rb;
      logic [7:0]      imm;
      logic [7:0]      flags;
      logic            sel;
      logic [PC_W-1:0] pc;
      int              cyc;
   } exp_t;

   exp_t            sb[$];
   int              wq[$];
   logic [15:0]     dq[$];
   int              n_chk = 0;
   int              n_fail = 0;
   int              cyc = 0;
   int              n_fetch = 0;
   int              max_wait = 3;
   logic [PC_W-1:0] model_pc = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Instruction memory responder
   initial begin
      int          wait_left;
      logic [15:0] d;
      exp_t        e;
      wait_left = -1;
      imem_ack  = 1'b0;
      imem_data = '0;
      forever begin
         @(posedge clk);
         #1;
         imem_ack = 1'b0;
         if (imem_req && rst_n) begin
            if (wait_left < 0) begin
               if (wq.size() != 0) wait_left = wq.pop_front();
               else                wait_left = $urandom_range(0, max_wait);
            end
            if (wait_left == 0) begin
               if (dq.size() != 0) d = dq.pop_front();
               else                d = 16'($urandom);
               imem_ack  = 1'b1;
               imem_data = d;
               wait_left = -1;
               chk("fetch_addr", 32'(imem_addr), 32'(model_pc));
               e.op    = d[15:12];
               e.wa    = d[11:8];
               e.ra    = d[7:4];
               e.rb    = d[3:0];
               e.imm   = d[7:0];
               e.flags = rom_flags(d[15:12]);
               e.sel   = (d[15:12] == 4'hF);
               e.pc    = model_pc;
               e.cyc   = cyc + 3;
               sb.push_back(e);
               model_pc = model_pc + 1'b1;
               n_fetch++;
            end else begin
               wait_left--;
            end
         end else begin
            wait_left = -1;
         end
      end
   end

   // Monitor: writeback scoreboard plus run/step sequencing rules
   initial begin
      logic pend_wb;
      logic pend_idle;
      logic run_wb;
      logic start_exp;
      exp_t e;
      pend_wb   = 1'b0;
      pend_idle = 1'b0;
      run_wb    = 1'b0;
      start_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend_wb   = 1'b0;
            pend_idle = 1'b0;
         end else begin
            if (pend_wb) begin
               chk("post_wb_busy", 32'(busy), 32'(run_wb));
               chk("post_wb_req", 32'(imem_req), 32'(run_wb));
            end
            if (pend_idle) chk("idle_start", 32'(busy), 32'(start_exp));
            pend_wb   = 1'b0;
            pend_idle = 1'b0;
            if (rf_we) begin
               n_chk++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_rf_we: got rf_we=1, required no writeback pending (t=%0t)", $time);
               end else begin
                  n_chk--;
                  e = sb.pop_front();
                  chk("wb_opcode", 32'(dec_opcode), 32'(e.op));
                  chk("wb_rf_wa", 32'(rf_wa), 32'(e.wa));
                  chk("wb_rf_ra", 32'(rf_ra), 32'(e.ra));
                  chk("wb_rf_rb", 32'(rf_rb), 32'(e.rb));
                  chk("wb_imm", 32'(imm), 32'(e.imm));
                  chk("wb_alu_flags", 32'(alu_flags), 32'(e.flags));
                  chk("wb_sel_imm", 32'(wb_sel_imm), 32'(e.sel));
                  chk("wb_pc", 32'(pc), 32'(e.pc));
                  chk("wb_latency", 32'(cyc), 32'(e.cyc));
               end
               pend_wb = 1'b1;
               run_wb  = run;
            end
            if (!busy) begin
               pend_idle = 1'b1;
               start_exp = run | step;
            end
         end
      end
   end

   task automatic wait_idle(input int lim);
      int k;
      k = 0;
      while ((busy || sb.size() != 0) && k < lim) begin
         @(negedge clk);
         k++;
      end
      n_chk++;
      if (busy || sb.size() != 0) begin
         n_fail++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d, required idle with nothing pending", busy, sb.size());
      end
   endtask

   task automatic step_one(input logic [15:0] d, input int w);
      dq.push_back(d);
      wq.push_back(w);
      @(posedge clk); #1;
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      wait_idle(50);
      @(negedge clk);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      run   = 1'b0;
      step  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_we", 32'(rf_we), 0);
      chk("rst_flags", 32'(alu_flags), 0);
      chk("rst_sel", 32'(wb_sel_imm), 0);
      chk("rst_imm", 32'(imm), 0);
      chk("rst_rf", 32'({rf_ra, rf_rb, rf_wa}), 0);
      #1 rst_n = 1'b1;

      // Directed single steps
      step_one(16'h0312, 2);
      chk("add_wa", 32'(rf_wa), 3);
      chk("add_ra", 32'(rf_ra), 1);
      chk("add_rb", 32'(rf_rb), 2);
      chk("add_flags", 32'(alu_flags), 0);
      chk("add_pc", 32'(pc), 1);
      step_one(16'hF5A7, 0);
      chk("ldi_sel", 32'(wb_sel_imm), 1);
      chk("ldi_imm", 32'(imm), 32'h A7);
      chk("ldi_wa", 32'(rf_wa), 5);
      chk("ldi_pc", 32'(pc), 2);
      step_one(16'h1012, 1);
      chk("sub_flags", 32'(alu_flags), 32'h C0);
      chk("sub_sel", 32'(wb_sel_imm), 0);
      chk("sub_pc", 32'(pc), 3);

      // Random run/step traffic with wait states
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 15) == 0) run = ~run;
         step = ($urandom_range(0, 3) == 0);
      end

      // Zero-wait free run across the pc wrap, step held high throughout
      max_wait = 0;
      @(posedge clk); #1;
      run  = 1'b1;
      step = 1'b1;
      k = 0;
      while (n_fetch < 600 && k < 3000) begin
         @(posedge clk);
         k++;
      end
      chk("wrap_progress", 32'(n_fetch >= 600), 1);

      // Drop run during EXEC: instruction completes, then IDLE
      step = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!imem_ack && k < 20);
      @(posedge clk); #1;
      @(posedge clk); #1;
      run = 1'b0;
      wait_idle(50);
      max_wait = 3;

      // Reset in the middle of a long fetch
      wq.push_back(10);
      @(posedge clk); #1;
      run = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!imem_req && k < 20);
      #2 rst_n = 1'b0;
      #1;
      chk("midfetch_req", 32'(imem_req), 0);
      chk("midfetch_pc", 32'(pc), 0);
      chk("midfetch_busy", 32'(busy), 0);
      run = 1'b0;
      sb.delete();
      model_pc = '0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", 32'(busy), 0);
         chk("post_rst_req", 32'(imem_req), 0);
      end
      step_one(16'h2468, 1);
      chk("post_rst_pc", 32'(pc), 1);

      wait_idle(50);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
